// File: rtl/multiword_add_seq_if.sv
// Operand, adder and result signals of the sequential multiword adder.
// The slave modport is the adder block; the master modport is its environment.
interface multiword_add_seq_if #(
    parameter int NWORDS = 4,
    parameter int W      = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [NWORDS*W-1:0] op_a;
    logic [NWORDS*W-1:0] op_b;
    logic                in_cin;
    logic [W-1:0]        add_a;
    logic [W-1:0]        add_b;
    logic                add_cin;
    logic [W-1:0]        add_sum;
    logic                add_cout;
    logic                out_valid;
    logic                out_ready;
    logic [NWORDS*W-1:0] result;
    logic                out_cout;
    logic                busy;

    modport slave (
        input  in_valid, op_a, op_b, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, result, out_cout, busy
    );

    modport master (
        output in_valid, op_a, op_b, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, result, out_cout, busy
    );
endinterface

// File: rtl/multiword_add_seq.sv
// Adds two NWORDS*16-bit operands one 16-bit word per cycle through an
// external combinational adder, rippling the carry through a register.
module multiword_add_seq #(
    parameter int NWORDS = 4,
    parameter int W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    multiword_add_seq_if.slave   bus
);
    localparam int KW = $clog2(NWORDS);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [KW-1:0]       r_k;
    logic [NWORDS*W-1:0] r_a;
    logic [NWORDS*W-1:0] r_b;
    logic                r_carry;
    logic [NWORDS*W-1:0] r_result;
    logic                r_cout;
    logic                w_last;

    assign w_last = (r_k == KW'(NWORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_nextState = ADD;
            ADD:     if (w_last)        w_nextState = DONE;
            DONE:    if (bus.out_ready) w_nextState = IDLE;
            default:                    w_nextState = IDLE;
        endcase
    end

    // Operands are captured only on accept, so input changes during ADD/DONE are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a      <= bus.op_a;
                        r_b      <= bus.op_b;
                        r_carry  <= bus.in_cin;
                        r_k      <= '0;
                        r_result <= '0;
                        r_cout   <= 1'b0;
                    end
                end
                ADD: begin
                    r_result[r_k*W +: W] <= bus.add_sum;
                    r_carry              <= bus.add_cout;
                    if (w_last) begin
                        r_k    <= '0;
                        r_cout <= bus.add_cout;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        if (r_state == ADD) begin
            bus.add_a   = r_a[r_k*W +: W];
            bus.add_b   = r_b[r_k*W +: W];
            bus.add_cin = r_carry;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state == ADD);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.out_cout  = r_cout;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: directed corner cases plus
// randomized operands compared against a plain wide-integer addition.
module tb_multiword_add_seq;
    localparam int NW = 4;
    localparam int T  = NW * 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    multiword_add_seq_if #(.NWORDS(NW), .W(16)) bus ();

    multiword_add_seq #(.NWORDS(NW), .W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The external 16-bit combinational adder.
    assign {bus.add_cout, bus.add_sum} = bus.add_a + bus.add_b + {16'd0, bus.add_cin};

    always #5 clk = ~clk;

    function automatic logic [T:0] refAdd(input logic [T-1:0] a, input logic [T-1:0] b, input logic cin);
        logic [T:0] s;
        s = {1'b0, a} + {1'b0, b} + {{T{1'b0}}, cin};
        return s;
    endfunction

    function automatic logic [T-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Drives one accept, scrambles the operand inputs afterwards and waits for out_valid.
    // lat counts cycles with the accepting cycle as cycle 1; -1 means a timeout.
    task automatic run_op(input logic [T-1:0] a, input logic [T-1:0] b, input logic cin, output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            lat = -1;
            return;
        end
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_cin   = cin;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op_a     = rand64();
        bus.op_b     = rand64();
        bus.in_cin   = 1'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op_a      = rand64();
        bus.op_b      = rand64();
        bus.in_cin    = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got in_ready=%b busy=%b out_valid=%b, want 1 0 0",
                     bus.in_ready, bus.busy, bus.out_valid);
        end
        checks++;
        if (bus.result !== '0 || bus.out_cout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_data: got result=%h cout=%b, want 0 0", bus.result, bus.out_cout);
        end
        checks++;
        if (bus.add_a !== 16'd0 || bus.add_b !== 16'd0 || bus.add_cin !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_adder: got add_a=%h add_b=%h add_cin=%b, want 0 0 0",
                     bus.add_a, bus.add_b, bus.add_cin);
        end
    endtask

    task automatic test_directed();
        logic [T-1:0] a [3];
        logic [T-1:0] b [3];
        logic         c [3];
        logic [T:0]   exp [3];
        int           lat;
        a[0] = 64'hFFFF_FFFF_FFFF_FFFF; b[0] = 64'd1;                 c[0] = 1'b0;
        exp[0] = {1'b1, 64'h0};
        a[1] = 64'h0001_0002_0003_0004; b[1] = 64'h0010_0020_0030_0040; c[1] = 1'b1;
        exp[1] = {1'b0, 64'h0011_0022_0033_0045};
        a[2] = 64'h0000_FFFF_FFFF_FFFF; b[2] = 64'd0;                 c[2] = 1'b1;
        exp[2] = {1'b0, 64'h0001_0000_0000_0000};
        for (int i = 0; i < 3; i++) begin
            run_op(a[i], b[i], c[i], lat);
            checks++;
            if (lat !== NW + 1) begin
                errors++;
                $display("[TB] FAIL directed%0d_latency: got %0d, want %0d", i, lat, NW + 1);
            end
            checks++;
            if ({bus.out_cout, bus.result} !== exp[i]) begin
                errors++;
                $display("[TB] FAIL directed%0d_sum: got cout=%b result=%h, want cout=%b result=%h",
                         i, bus.out_cout, bus.result, exp[i][T], exp[i][T-1:0]);
            end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        logic [T-1:0] a;
        logic [T-1:0] b;
        logic [T:0]   exp;
        int           lat;
        a   = rand64();
        b   = rand64();
        exp = refAdd(a, b, 1'b1);
        run_op(a, b, 1'b1, lat);
        checks++;
        if (lat !== NW + 1) begin
            errors++;
            $display("[TB] FAIL hold_latency: got %0d, want %0d", lat, NW + 1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.out_cout, bus.result} !== exp) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got valid=%b in_ready=%b cout=%b result=%h, want 1 0 %b %h",
                         i, bus.out_valid, bus.in_ready, bus.out_cout, bus.result, exp[T], exp[T-1:0]);
            end
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL handshake_in_ready: got %b, want 0", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_handshake: got in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.op_b     = 64'h1;
        bus.in_cin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_busy: got %b, want 1", bus.busy);
        end
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_no_output: got %0d valid cycles in_ready=%b, want 0 1", seen, bus.in_ready);
        end
        run_op(64'd5, 64'd3, 1'b0, lat);
        checks++;
        if (lat !== NW + 1 || bus.result !== 64'd8 || bus.out_cout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_abort_op: got lat=%0d result=%h cout=%b, want %0d 8 0",
                     lat, bus.result, bus.out_cout, NW + 1);
        end
        finish_op();
    endtask

    task automatic test_random();
        logic [T-1:0] a;
        logic [T-1:0] b;
        logic         c;
        logic [T:0]   exp;
        int           lat;
        for (int i = 0; i < 1000; i++) begin
            a = rand64();
            b = rand64();
            if ($urandom_range(7) == 0) a = '1;
            if ($urandom_range(7) == 0) b = ~a;
            c   = 1'($urandom);
            exp = refAdd(a, b, c);
            run_op(a, b, c, lat);
            checks++;
            if (lat !== NW + 1 || {bus.out_cout, bus.result} !== exp) begin
                errors++;
                $display("[TB] FAIL random%0d: got lat=%0d cout=%b result=%h, want %0d %b %h",
                         i, lat, bus.out_cout, bus.result, NW + 1, exp[T], exp[T-1:0]);
            end
            repeat ($urandom_range(2)) @(negedge clk);
            finish_op();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter NWORDS, default 4: number of 16-bit words per operand (allowed range 2..8).
REQ-002 SHALL have parameter W, default 16: adder slice width, fixed at 16.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1: operand pair offered.
REQ-006 SHALL have port in_ready  output  1: block accepts an operand pair this cycle.
REQ-007 SHALL have port op_a  input  NWORDS*16: operand A, word 0 = bits [15:0].
REQ-008 SHALL have port op_b  input  NWORDS*16: operand B.
REQ-009 SHALL have port in_cin  input  1: carry into word 0.
REQ-010 SHALL have port add_a  output  16: A-word driven to the external 16-bit combinational adder.
REQ-011 SHALL have port add_b  output  16: B-word driven to the adder.
REQ-012 SHALL have port add_cin  output  1: carry driven to the adder.
REQ-013 SHALL have port add_sum  input  16: adder sum, combinational from add_a/add_b/add_cin.
REQ-014 SHALL have port add_cout  input  1: adder carry-out.
REQ-015 SHALL have port out_valid  output  1: result available.
REQ-016 SHALL have port out_ready  input  1: consumer takes result.
REQ-017 SHALL have port result  output  NWORDS*16: full-width sum.
REQ-018 SHALL have port out_cout  output  1: final carry-out.
REQ-019 SHALL have port busy  output  1: high in state ADD.

Function
REQ-020 SHALL implement FSM states IDLE, ADD, DONE.
REQ-021 SHALL assert in_ready only in IDLE; accept occurs on in_valid && in_ready.
REQ-022 SHALL, on accept, register op_a, op_b, in_cin, clear word index k to 0 and the result register, and go to ADD.
REQ-023 SHALL, in ADD, drive add_a = A word k, add_b = B word k, add_cin = registered carry (in_cin for k=0, else previous add_cout).
REQ-024 SHALL, each ADD cycle, write add_sum into result word k, register add_cout as carry, and increment k.
REQ-025 SHALL leave ADD for DONE on the cycle k = NWORDS-1 completes; out_cout = add_cout of that cycle.
REQ-026 SHALL assert out_valid in DONE only; first out_valid exactly NWORDS+1 cycles after the accepting edge (NWORDS ADD cycles).
REQ-027 SHALL hold result and out_cout stable while out_valid=1 and out_ready=0.
REQ-028 SHALL return to IDLE on out_valid && out_ready; in_ready rises the following cycle (no same-cycle re-accept).
REQ-029 SHALL drive add_a=0, add_b=0, add_cin=0 outside ADD.
REQ-030 SHALL ignore in_valid and op_* changes outside IDLE; captured operands are unaffected.
REQ-031 SHALL compute result modulo 2^(16*NWORDS); overflow only reported via out_cout.
REQ-032 SHALL size k to ceil(log2(NWORDS)) bits minimum; k never exceeds NWORDS-1.

Reset
REQ-033 SHALL, with rst=1 at a clock edge, enter IDLE, clear k, carry, result, out_cout, out_valid, busy to 0.
REQ-034 SHALL, with rst=1 at a clock edge, set in_ready=1 from the first cycle after rst deasserts.
REQ-035 SHALL, on rst mid-ADD or in DONE, abort without emitting out_valid for the aborted operation.
REQ-036 SHALL give rst priority over accept and over the out handshake in the same cycle.

Verification
REQ-037 SHALL cover: A=0xFFFF_FFFF_FFFF_FFFF, B=1, cin=0 -> result 0, out_cout=1, out_valid 5 cycles after accept.
REQ-038 SHALL cover: A=0x0001_0002_0003_0004, B=0x0010_0020_0030_0040, cin=1 -> result 0x0011_0022_0033_0045, out_cout=0.
REQ-039 SHALL cover: carry ripple A=0x0000_FFFF_FFFF_FFFF, B=0, cin=1 -> result 0x0001_0000_0000_0000, out_cout=0.
REQ-040 SHALL cover: out_ready low 10 cycles in DONE -> result/out_valid held; in_ready=0 until the cycle after handshake.
REQ-041 SHALL cover: rst pulsed at k=2 -> out_valid never asserts; next op 5+3 (cin=0) yields 8 normally.
REQ-042 SHALL cover: 1000 random operand/cin triples checked against a golden 64-bit add with carry-out.
